// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl: round and duck sequencing engine for the Duck Hunt game.
// It runs NUM_DUCKS ducks through fly, fall and escape, counts bullets, tests
// shots against the sniper cursor, keeps the score and sequences rounds up to
// game over. Everything runs on the pixel clock. Motion advances only on the
// one-cycle frame tick.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   tick                one-clk frame pulse
//   start               level, starts a new game from GAME_OVER
//   b_shoot             debounced trigger level (rising edge = shot)
//   speed               extra x step per tick
//   sniper_x/sniper_y   cursor top-left
//   rand_in             random bits used for the spawn height
//   duck_x/duck_y       packed positions, duck i at [i*X_W +: X_W]
//   duck_falling        bit i = duck i falling
//   duck_visible        bit i = duck i flying or falling
//   bullets_left        shots remaining this round
//   score               total hits, saturating
//   dog_show            round ended with enough hits
//   game_over           game over screen
//
// Round FSM states:
//   state        | meaning
//   R_START      | waiting for a tick to spawn a new round
//   R_PLAY       | ducks flying/falling, shots accepted
//   R_ROUND_END  | result display for SHOW_TICKS ticks
//   R_GAME_OVER  | waiting for start
//
// Duck FSM states:
//   state        | meaning
//   D_IDLE       | not yet spawned
//   D_FLY        | zig-zag flight to the right, can be hit
//   D_FALL       | shot, dropping to the ground
//   D_ESCAPED    | left the screen, parked
//   D_DOWN       | on the ground, parked
module duck_round_ctrl #(
   parameter int NUM_DUCKS  = 2,
   parameter int BULLETS    = 3,
   parameter int WIN_HITS   = 1,
   parameter int X_W        = 11,
   parameter int X_START    = 10,
   parameter int X_EDGE     = 1200,
   parameter int GROUND_Y   = 600,
   parameter int FALL_STEP  = 5,
   parameter int BAND       = 30,
   parameter int SHOW_TICKS = 60,
   parameter int SCORE_W    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     start,
   input  logic                     b_shoot,
   input  logic [2:0]               speed,
   input  logic [X_W-1:0]           sniper_x,
   input  logic [X_W-1:0]           sniper_y,
   input  logic [3:0]               rand_in,
   output logic [NUM_DUCKS*X_W-1:0] duck_x,
   output logic [NUM_DUCKS*X_W-1:0] duck_y,
   output logic [NUM_DUCKS-1:0]     duck_falling,
   output logic [NUM_DUCKS-1:0]     duck_visible,
   output logic [2:0]               bullets_left,
   output logic [SCORE_W-1:0]       score,
   output logic                     dog_show,
   output logic                     game_over
);

   localparam int XE    = X_W + 1;
   localparam int CNT_W = $clog2(SHOW_TICKS + 1);

   localparam logic [2:0]       WIN_C     = 3'(WIN_HITS);
   localparam logic [2:0]       BULLETS_C = 3'(BULLETS);
   localparam logic [XE-1:0]    EDGE_C    = XE'(X_EDGE);
   localparam logic [XE-1:0]    GROUND_C  = XE'(GROUND_Y);
   localparam logic [XE-1:0]    BAND_C    = XE'(BAND);
   localparam logic [CNT_W-1:0] SHOW_C    = CNT_W'(SHOW_TICKS);

   typedef enum logic [1:0] {R_START, R_PLAY, R_ROUND_END, R_GAME_OVER} round_t;
   typedef enum logic [2:0] {D_IDLE, D_FLY, D_FALL, D_ESCAPED, D_DOWN} duck_t;

   round_t round_state, round_next;
   duck_t  duck_state [NUM_DUCKS];

   logic [X_W-1:0]       x_r    [NUM_DUCKS];
   logic [X_W-1:0]       y_r    [NUM_DUCKS];
   logic [X_W-1:0]       base_r [NUM_DUCKS];
   logic [NUM_DUCKS-1:0] up_r;
   logic                 b_shoot_q;
   logic [2:0]           round_hits;
   logic [CNT_W-1:0]     show_cnt;

   logic [X_W-1:0]       x_fly   [NUM_DUCKS];
   logic [X_W-1:0]       y_fly   [NUM_DUCKS];
   logic [X_W-1:0]       y_fall  [NUM_DUCKS];
   logic [X_W-1:0]       spawn_y [NUM_DUCKS];
   logic [NUM_DUCKS-1:0] up_fly, escape, land, qual, hit_sel;
   logic                 shot_ok;
   logic [XE-1:0]        sx_e, sy_e;

   assign sx_e    = {1'b0, sniper_x};
   assign sy_e    = {1'b0, sniper_y};
   assign shot_ok = b_shoot & ~b_shoot_q & (round_state == R_PLAY) & (bullets_left != 3'd0);

   for (genvar g = 0; g < NUM_DUCKS; g++) begin : g_duck
      logic [XE-1:0] x_e, y_e, b_e, x_sum, hi, lo, y_down;
      logic          up_eff;

      assign x_e    = {1'b0, x_r[g]};
      assign y_e    = {1'b0, y_r[g]};
      assign b_e    = {1'b0, base_r[g]};
      assign x_sum  = x_e + XE'(speed) + XE'(3);
      assign hi     = b_e + BAND_C + XE'(speed);
      assign lo     = (b_e > BAND_C) ? (b_e - BAND_C) : '0;
      // direction is settled before the step so y never exceeds [lo, hi]
      assign up_eff = (y_e >= hi) ? 1'b0 : (y_e <= lo) ? 1'b1 : up_r[g];
      assign y_down = y_e + XE'(FALL_STEP);

      assign x_fly[g]   = x_sum[X_W-1:0];
      assign escape[g]  = x_sum[X_W] | (x_sum >= EDGE_C);
      assign y_fly[g]   = up_eff ? (y_r[g] + X_W'(1)) : (y_r[g] - X_W'(1));
      assign up_fly[g]  = up_eff;
      assign y_fall[g]  = y_down[X_W-1:0];
      assign land[g]    = y_down >= GROUND_C;
      assign spawn_y[g] = X_W'(rand_in ^ 4'(g)) * X_W'(25) + X_W'(40);

      assign qual[g] = shot_ok && (duck_state[g] == D_FLY)
                    && (sx_e + XE'(25) > x_e) && (sx_e < x_e + XE'(40))
                    && (sy_e + XE'(20) > y_e) && (sy_e < y_e + XE'(40));

      assign duck_x[g*X_W +: X_W] = x_r[g];
      assign duck_y[g*X_W +: X_W] = y_r[g];
      assign duck_falling[g]      = (duck_state[g] == D_FALL);
      assign duck_visible[g]      = (duck_state[g] == D_FLY) || (duck_state[g] == D_FALL);
   end

   // isolate the lowest set bit: only the lowest-index duck takes the shot
   assign hit_sel = qual & (~qual + NUM_DUCKS'(1));

   assign dog_show  = (round_state == R_ROUND_END) && (round_hits >= WIN_C);
   assign game_over = (round_state == R_GAME_OVER);

   always_ff @(posedge clk) begin
      if (rst) round_state <= R_START;
      else     round_state <= round_next;
   end

   always_comb begin
      round_next = round_state;
      case (round_state)
         R_START:     if (tick) round_next = R_PLAY;
         R_PLAY:      if (duck_visible == '0) round_next = R_ROUND_END;
         R_ROUND_END: if (tick && show_cnt == CNT_W'(1))
                         round_next = (round_hits >= WIN_C) ? R_START : R_GAME_OVER;
         R_GAME_OVER: if (start) round_next = R_START;
         default:     round_next = R_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DUCKS; i++) begin
            duck_state[i] <= D_IDLE;
            x_r[i]        <= X_W'(X_START);
            y_r[i]        <= '0;
            base_r[i]     <= '0;
         end
         up_r         <= '0;
         bullets_left <= BULLETS_C;
         score        <= '0;
         round_hits   <= '0;
         b_shoot_q    <= 1'b0;
         show_cnt     <= '0;
      end else begin
         b_shoot_q <= b_shoot;
         case (round_state)
            R_START: begin
               if (tick) begin
                  for (int i = 0; i < NUM_DUCKS; i++) begin
                     duck_state[i] <= D_FLY;
                     x_r[i]        <= X_W'(X_START);
                     y_r[i]        <= spawn_y[i];
                     base_r[i]     <= spawn_y[i];
                  end
                  up_r         <= '1;
                  bullets_left <= BULLETS_C;
                  round_hits   <= '0;
               end
            end
            R_PLAY: begin
               if (shot_ok) begin
                  bullets_left <= bullets_left - 3'd1;
                  if (hit_sel != '0) begin
                     round_hits <= round_hits + 3'd1;
                     if (score != '1) score <= score + SCORE_W'(1);
                  end
               end
               // a duck hit this clk freezes even if the tick lands too
               for (int i = 0; i < NUM_DUCKS; i++) begin
                  if (hit_sel[i]) begin
                     duck_state[i] <= D_FALL;
                  end else if (tick && duck_state[i] == D_FLY) begin
                     x_r[i]  <= x_fly[i];
                     y_r[i]  <= y_fly[i];
                     up_r[i] <= up_fly[i];
                     if (escape[i]) duck_state[i] <= D_ESCAPED;
                  end else if (tick && duck_state[i] == D_FALL) begin
                     y_r[i] <= y_fall[i];
                     if (land[i]) duck_state[i] <= D_DOWN;
                  end
               end
               if (round_next == R_ROUND_END) show_cnt <= SHOW_C;
            end
            R_ROUND_END: begin
               if (tick && show_cnt != CNT_W'(1)) show_cnt <= show_cnt - CNT_W'(1);
            end
            R_GAME_OVER: begin
               if (start) score <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl with default parameters (2 ducks,
// 3 bullets, 1 win hit). Inputs change 1 ns after the rising edge and outputs
// are sampled at the same point, so every value read reflects the edge just
// taken.
module tb_duck_round_ctrl;

   localparam int X_W = 11;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 tick = 1'b0;
   logic                 start = 1'b0;
   logic                 b_shoot = 1'b0;
   logic [2:0]           speed = 3'd0;
   logic [X_W-1:0]       sniper_x = '0;
   logic [X_W-1:0]       sniper_y = '0;
   logic [3:0]           rand_in = 4'd0;
   logic [2*X_W-1:0]     duck_x, duck_y;
   logic [1:0]           duck_falling, duck_visible;
   logic [2:0]           bullets_left;
   logic [3:0]           score;
   logic                 dog_show, game_over;

   int total = 0;
   int bad   = 0;

   duck_round_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .start        (start),
      .b_shoot      (b_shoot),
      .speed        (speed),
      .sniper_x     (sniper_x),
      .sniper_y     (sniper_y),
      .rand_in      (rand_in),
      .duck_x       (duck_x),
      .duck_y       (duck_y),
      .duck_falling (duck_falling),
      .duck_visible (duck_visible),
      .bullets_left (bullets_left),
      .score        (score),
      .dog_show     (dog_show),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         @(posedge clk);
         #1;
         tick = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(2);
      total++; if (duck_visible !== 2'b00) begin bad++; $display("FAIL reset_visible got=%b exp=00", duck_visible); end
      total++; if (duck_x !== {11'd10, 11'd10}) begin bad++; $display("FAIL reset_x got=%h exp=%h", duck_x, {11'd10, 11'd10}); end
      total++; if (duck_y !== 22'd0) begin bad++; $display("FAIL reset_y got=%h exp=0", duck_y); end
      total++; if (bullets_left !== 3'd3) begin bad++; $display("FAIL reset_bullets got=%0d exp=3", bullets_left); end
      total++; if ({score, dog_show, game_over, duck_falling} !== 8'd0) begin bad++; $display("FAIL reset_misc got=%b exp=0", {score, dog_show, game_over, duck_falling}); end
      rst = 1'b0;
      rand_in = 4'd0;
      speed = 3'd2;
      do_ticks(1);
      total++; if (duck_visible !== 2'b11) begin bad++; $display("FAIL spawn_visible got=%b exp=11", duck_visible); end
      total++; if (duck_x !== {11'd10, 11'd10}) begin bad++; $display("FAIL spawn_x got=%h exp=%h", duck_x, {11'd10, 11'd10}); end
      total++; if (duck_y !== {11'd65, 11'd40}) begin bad++; $display("FAIL spawn_y got=%h exp=%h", duck_y, {11'd65, 11'd40}); end
      total++; if (bullets_left !== 3'd3 || score !== 4'd0) begin bad++; $display("FAIL spawn_bullets_score got=%0d/%0d exp=3/0", bullets_left, score); end
   endtask

   task automatic test_fly;
      do_ticks(10);
      total++; if (duck_x !== {11'd60, 11'd60}) begin bad++; $display("FAIL fly10_x got=%h exp=%h", duck_x, {11'd60, 11'd60}); end
      total++; if (duck_y !== {11'd75, 11'd50}) begin bad++; $display("FAIL fly10_y got=%h exp=%h", duck_y, {11'd75, 11'd50}); end
      do_ticks(22);
      total++; if (duck_y !== {11'd97, 11'd72}) begin bad++; $display("FAIL fly_top_y got=%h exp=%h", duck_y, {11'd97, 11'd72}); end
      do_ticks(1);
      total++; if (duck_y !== {11'd96, 11'd71}) begin bad++; $display("FAIL fly_turn_y got=%h exp=%h", duck_y, {11'd96, 11'd71}); end
      total++; if (duck_x !== {11'd175, 11'd175}) begin bad++; $display("FAIL fly33_x got=%h exp=%h", duck_x, {11'd175, 11'd175}); end
   endtask

   task automatic test_hit_fall;
      sniper_x = 11'd165;
      sniper_y = 11'd76;
      b_shoot = 1'b1;
      step(1);
      total++; if (bullets_left !== 3'd2) begin bad++; $display("FAIL hit_bullets got=%0d exp=2", bullets_left); end
      total++; if (duck_falling !== 2'b01) begin bad++; $display("FAIL hit_falling got=%b exp=01", duck_falling); end
      total++; if (score !== 4'd1) begin bad++; $display("FAIL hit_score got=%0d exp=1", score); end
      step(4);
      total++; if (bullets_left !== 3'd2 || score !== 4'd1) begin bad++; $display("FAIL held_trigger got=%0d/%0d exp=2/1", bullets_left, score); end
      b_shoot = 1'b0;
      step(1);
      do_ticks(1);
      total++; if (duck_y[10:0] !== 11'd76) begin bad++; $display("FAIL fall_y1 got=%0d exp=76", duck_y[10:0]); end
      total++; if (duck_x !== {11'd180, 11'd175}) begin bad++; $display("FAIL fall_x1 got=%h exp=%h", duck_x, {11'd180, 11'd175}); end
      do_ticks(104);
      total++; if (duck_y[10:0] !== 11'd596 || duck_falling !== 2'b01) begin bad++; $display("FAIL fall_before_ground got=%0d/%b exp=596/01", duck_y[10:0], duck_falling); end
      do_ticks(1);
      total++; if (duck_y[10:0] !== 11'd601) begin bad++; $display("FAIL fall_ground_y got=%0d exp=601", duck_y[10:0]); end
      total++; if (duck_falling !== 2'b00 || duck_visible !== 2'b10) begin bad++; $display("FAIL fall_down_flags got=%b/%b exp=00/10", duck_falling, duck_visible); end
   endtask

   task automatic test_round_win;
      do_ticks(98);
      total++; if (duck_x[21:11] !== 11'd1195 || duck_visible !== 2'b10) begin bad++; $display("FAIL pre_escape got=%0d/%b exp=1195/10", duck_x[21:11], duck_visible); end
      do_ticks(1);
      total++; if (duck_x[21:11] !== 11'd1200 || duck_visible !== 2'b00) begin bad++; $display("FAIL escape got=%0d/%b exp=1200/00", duck_x[21:11], duck_visible); end
      step(1);
      total++; if (dog_show !== 1'b1) begin bad++; $display("FAIL dog_on got=%b exp=1", dog_show); end
      do_ticks(59);
      total++; if (dog_show !== 1'b1) begin bad++; $display("FAIL dog_hold got=%b exp=1", dog_show); end
      do_ticks(1);
      total++; if (dog_show !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL dog_off got=%b/%b exp=0/0", dog_show, game_over); end
      b_shoot = 1'b1;
      step(1);
      b_shoot = 1'b0;
      step(1);
      total++; if (bullets_left !== 3'd2) begin bad++; $display("FAIL shot_in_start got=%0d exp=2", bullets_left); end
      speed = 3'd7;
      do_ticks(1);
      total++; if (bullets_left !== 3'd3 || score !== 4'd1 || duck_visible !== 2'b11) begin bad++; $display("FAIL round2_spawn got=%0d/%0d/%b exp=3/1/11", bullets_left, score, duck_visible); end
   endtask

   task automatic test_game_over;
      sniper_x = 11'd1000;
      sniper_y = 11'd1000;
      for (int k = 0; k < 3; k++) begin
         b_shoot = 1'b1;
         step(1);
         total++; if (bullets_left !== 3'(2 - k)) begin bad++; $display("FAIL miss_bullets%0d got=%0d exp=%0d", k, bullets_left, 2 - k); end
         b_shoot = 1'b0;
         step(1);
      end
      b_shoot = 1'b1;
      step(1);
      b_shoot = 1'b0;
      step(1);
      total++; if (bullets_left !== 3'd0 || score !== 4'd1) begin bad++; $display("FAIL empty_gun got=%0d/%0d exp=0/1", bullets_left, score); end
      do_ticks(118);
      total++; if (duck_x !== {11'd1190, 11'd1190} || duck_visible !== 2'b11) begin bad++; $display("FAIL miss_pre_escape got=%h/%b exp=%h/11", duck_x, duck_visible, {11'd1190, 11'd1190}); end
      do_ticks(1);
      total++; if (duck_visible !== 2'b00) begin bad++; $display("FAIL miss_escape got=%b exp=00", duck_visible); end
      step(1);
      total++; if (dog_show !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL lose_round_end got=%b/%b exp=0/0", dog_show, game_over); end
      do_ticks(59);
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL game_over_early got=%b exp=0", game_over); end
      do_ticks(1);
      total++; if (game_over !== 1'b1 || score !== 4'd1) begin bad++; $display("FAIL game_over got=%b/%0d exp=1/1", game_over, score); end
      start = 1'b1;
      step(1);
      start = 1'b0;
      total++; if (game_over !== 1'b0 || score !== 4'd0) begin bad++; $display("FAIL restart got=%b/%0d exp=0/0", game_over, score); end
   endtask

   task automatic test_overlap_tick;
      sniper_x = 11'd10;
      sniper_y = 11'd50;
      do_ticks(1);
      total++; if (duck_y !== {11'd65, 11'd40}) begin bad++; $display("FAIL r3_spawn_y got=%h exp=%h", duck_y, {11'd65, 11'd40}); end
      tick = 1'b1;
      b_shoot = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      b_shoot = 1'b0;
      total++; if (duck_falling !== 2'b01) begin bad++; $display("FAIL overlap_lowest got=%b exp=01", duck_falling); end
      total++; if (duck_x !== {11'd20, 11'd10}) begin bad++; $display("FAIL coincident_x got=%h exp=%h", duck_x, {11'd20, 11'd10}); end
      total++; if (duck_y !== {11'd66, 11'd40}) begin bad++; $display("FAIL coincident_y got=%h exp=%h", duck_y, {11'd66, 11'd40}); end
      total++; if (score !== 4'd1 || bullets_left !== 3'd2) begin bad++; $display("FAIL overlap_score got=%0d/%0d exp=1/2", score, bullets_left); end
      do_ticks(10);
      total++; if (duck_y[10:0] !== 11'd90 || duck_x[10:0] !== 11'd10) begin bad++; $display("FAIL r3_fall got=%0d/%0d exp=90/10", duck_y[10:0], duck_x[10:0]); end
   endtask

   task automatic test_reset_mid_fall;
      rst = 1'b1;
      step(1);
      total++; if (duck_visible !== 2'b00 || duck_falling !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b/%b exp=00/00", duck_visible, duck_falling); end
      total++; if (duck_x !== {11'd10, 11'd10} || duck_y !== 22'd0) begin bad++; $display("FAIL midrst_pos got=%h/%h exp=%h/0", duck_x, duck_y, {11'd10, 11'd10}); end
      total++; if (bullets_left !== 3'd3 || score !== 4'd0 || dog_show !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL midrst_misc got=%0d/%0d/%b/%b exp=3/0/0/0", bullets_left, score, dog_show, game_over); end
      rst = 1'b0;
      do_ticks(1);
      total++; if (duck_visible !== 2'b11 || bullets_left !== 3'd3) begin bad++; $display("FAIL post_rst_spawn got=%b/%0d exp=11/3", duck_visible, bullets_left); end
   endtask

   initial begin
      test_reset;
      test_fly;
      test_hit_fall;
      test_round_win;
      test_game_over;
      test_overlap_tick;
      test_reset_mid_fall;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
